// File: rtl/id_operand_stage.sv
// id_operand_stage: decode-side operand stage between the decoder and EX.
// Picks each source operand from a prioritised forwarding network, the
// register file or the immediate. It detects load-use hazards, resolves
// ID-stage branches and owns the ID/EX pipeline register.
// Optional build macro ID_STAT_EN adds saturating stall/bubble counters.

// Per-port operand mux: the lowest-index matching forward source wins.
module id_operand_sel #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int NUM_FWD = 2
) (
    input  logic                      re,
    input  logic [REG_AW-1:0]         raddr,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [DATA_W-1:0]         imm,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    output logic [DATA_W-1:0]         op,
    output logic                      youngest_hit
);
    // Walk oldest to youngest so the youngest match overrides; imm beats all.
    always_comb begin
        op = rf_data;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_we[k] && fwd_waddr[k*REG_AW +: REG_AW] == raddr)
                op = fwd_wdata[k*DATA_W +: DATA_W];
        end
        if (!re)
            op = imm;
    end

    // Match against the EX-stage source only; this feeds load-use detection.
    assign youngest_hit = re && fwd_we[0] && (fwd_waddr[REG_AW-1:0] == raddr);
endmodule

module id_operand_stage #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int NUM_FWD  = 2,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_i,
    input  logic [1:0]                re_i,
    input  logic [2*REG_AW-1:0]       raddr_i,
    input  logic [2*DATA_W-1:0]       rf_data_i,
    input  logic [DATA_W-1:0]         imm_i,
    input  logic                      we_i,
    input  logic [REG_AW-1:0]         waddr_i,
    input  logic [ALUOP_W-1:0]        aluop_i,
    input  logic [ALUSEL_W-1:0]       alusel_i,
    input  logic                      branch_i,
    input  logic [1:0]                bcond_i,
    input  logic [DATA_W-1:0]         btarget_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic                      ex_load_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    output logic                      stall_req_o,
    output logic                      branch_flag_o,
    output logic [DATA_W-1:0]         branch_addr_o,
    output logic                      ex_valid_o,
    output logic [DATA_W-1:0]         ex_op0_o,
    output logic [DATA_W-1:0]         ex_op1_o,
    output logic                      ex_we_o,
    output logic [REG_AW-1:0]         ex_waddr_o,
    output logic [ALUOP_W-1:0]        ex_aluop_o,
    output logic [ALUSEL_W-1:0]       ex_alusel_o
`ifdef ID_STAT_EN
    ,
    output logic [15:0]               stall_cnt_o,
    output logic [15:0]               bubble_cnt_o
`endif
);
    typedef struct packed {
        logic                valid;
        logic [DATA_W-1:0]   op0;
        logic [DATA_W-1:0]   op1;
        logic                we;
        logic [REG_AW-1:0]   waddr;
        logic [ALUOP_W-1:0]  aluop;
        logic [ALUSEL_W-1:0] alusel;
    } ex_t;

    logic [1:0][DATA_W-1:0] op;
    logic [1:0]             hit0;
    logic                   hz;
    logic                   cond;
    logic                   bubble_load;
    ex_t                    ex_q;

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_port
            id_operand_sel #(
                .DATA_W (DATA_W),
                .REG_AW (REG_AW),
                .NUM_FWD(NUM_FWD)
            ) u_sel (
                .re          (re_i[p]),
                .raddr       (raddr_i[p*REG_AW +: REG_AW]),
                .rf_data     (rf_data_i[p*DATA_W +: DATA_W]),
                .imm         (imm_i),
                .fwd_we      (fwd_we_i),
                .fwd_waddr   (fwd_waddr_i),
                .fwd_wdata   (fwd_wdata_i),
                .op          (op[p]),
                .youngest_hit(hit0[p])
            );
        end
    endgenerate

    // A load in EX cannot forward its data yet: any enabled port hitting it stalls.
    assign hz          = in_valid_i && ex_load_i && (|hit0);
    assign stall_req_o = hz && !flush_i;

    // Branch condition evaluated on the forwarded operand 0.
    always_comb begin
        case (bcond_i)
            2'b00:   cond = 1'b1;
            2'b01:   cond = (op[0] == '0);
            2'b10:   cond = (op[0] != '0);
            default: cond = 1'b0;
        endcase
    end

    assign branch_flag_o = in_valid_i && branch_i && !hz && cond;
    assign branch_addr_o = btarget_i;

    // Edges on which a NOP is written into ID/EX (reset edges excluded).
    assign bubble_load = flush_i || (!stall_i && (hz || !in_valid_i));

    // ID/EX register: reset > flush > stall hold > bubble > load.
    always_ff @(posedge clk) begin
        if (!rst)
            ex_q <= '0;
        else if (flush_i)
            ex_q <= '0;
        else if (stall_i)
            ex_q <= ex_q;
        else if (hz || !in_valid_i)
            ex_q <= '0;
        else
            ex_q <= '{valid: 1'b1, op0: op[0], op1: op[1], we: we_i,
                      waddr: waddr_i, aluop: aluop_i, alusel: alusel_i};
    end

    assign ex_valid_o  = ex_q.valid;
    assign ex_op0_o    = ex_q.op0;
    assign ex_op1_o    = ex_q.op1;
    assign ex_we_o     = ex_q.we;
    assign ex_waddr_o  = ex_q.waddr;
    assign ex_aluop_o  = ex_q.aluop;
    assign ex_alusel_o = ex_q.alusel;

`ifdef ID_STAT_EN
    // Saturating event counters for stall requests and inserted bubbles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (stall_req_o && stall_cnt_o != 16'hFFFF)
                stall_cnt_o <= stall_cnt_o + 16'd1;
            if (bubble_load && bubble_cnt_o != 16'hFFFF)
                bubble_cnt_o <= bubble_cnt_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage. A spec-level model predicts the
// combinational outputs and the ID/EX contents; every cycle is compared,
// and a few hand-computed literals pin the model itself.
module tb_id_operand_stage;
    localparam int DW = 16, AW = 4, NF = 2, OW = 8, SW = 3;

    logic            clk = 0;
    logic            rst;
    logic            in_valid;
    logic [1:0]      re;
    logic [2*AW-1:0] raddr;
    logic [2*DW-1:0] rf_data;
    logic [DW-1:0]   imm;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [OW-1:0]   aluop;
    logic [SW-1:0]   alusel;
    logic            branch;
    logic [1:0]      bcond;
    logic [DW-1:0]   btarget;
    logic [NF-1:0]   fwd_we;
    logic [NF*AW-1:0] fwd_waddr;
    logic [NF*DW-1:0] fwd_wdata;
    logic            ex_load, stall, flush;
    logic            stall_req, branch_flag;
    logic [DW-1:0]   branch_addr;
    logic            ex_valid;
    logic [DW-1:0]   ex_op0, ex_op1;
    logic            ex_we;
    logic [AW-1:0]   ex_waddr;
    logic [OW-1:0]   ex_aluop;
    logic [SW-1:0]   ex_alusel;
`ifdef ID_STAT_EN
    logic [15:0]     stall_cnt, bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Model state of the ID/EX register and counters.
    logic            m_valid, m_we;
    logic [DW-1:0]   m_op0, m_op1;
    logic [AW-1:0]   m_waddr;
    logic [OW-1:0]   m_aluop;
    logic [SW-1:0]   m_alusel;
    int              m_scnt, m_bcnt;

    always #5 clk = ~clk;

    id_operand_stage #(.DATA_W(DW), .REG_AW(AW), .NUM_FWD(NF), .ALUOP_W(OW), .ALUSEL_W(SW)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .re_i(re), .raddr_i(raddr),
        .rf_data_i(rf_data), .imm_i(imm), .we_i(we), .waddr_i(waddr),
        .aluop_i(aluop), .alusel_i(alusel), .branch_i(branch), .bcond_i(bcond),
        .btarget_i(btarget), .fwd_we_i(fwd_we), .fwd_waddr_i(fwd_waddr),
        .fwd_wdata_i(fwd_wdata), .ex_load_i(ex_load), .stall_i(stall), .flush_i(flush),
        .stall_req_o(stall_req), .branch_flag_o(branch_flag), .branch_addr_o(branch_addr),
        .ex_valid_o(ex_valid), .ex_op0_o(ex_op0), .ex_op1_o(ex_op1), .ex_we_o(ex_we),
        .ex_waddr_o(ex_waddr), .ex_aluop_o(ex_aluop), .ex_alusel_o(ex_alusel)
`ifdef ID_STAT_EN
        , .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Spec rule: imm if port disabled, else first matching forward source, else RF.
    function automatic logic [DW-1:0] f_op(input int p);
        logic [AW-1:0] a;
        a = raddr[p*AW +: AW];
        if (!re[p]) return imm;
        for (int k = 0; k < NF; k++)
            if (fwd_we[k] && fwd_waddr[k*AW +: AW] == a) return fwd_wdata[k*DW +: DW];
        return rf_data[p*DW +: DW];
    endfunction

    function automatic logic f_hz();
        logic any = 0;
        for (int p = 0; p < 2; p++)
            if (re[p] && raddr[p*AW +: AW] == fwd_waddr[AW-1:0]) any = 1;
        return in_valid && ex_load && fwd_we[0] && any;
    endfunction

    function automatic logic f_bflag();
        logic c;
        logic [DW-1:0] o0;
        o0 = f_op(0);
        c = (bcond == 2'b00) ? 1'b1 : (bcond == 2'b01) ? (o0 == 0) :
            (bcond == 2'b10) ? (o0 != 0) : 1'b0;
        return in_valid && branch && !f_hz() && c;
    endfunction

    task automatic m_bubble();
        m_valid = 0; m_we = 0; m_op0 = 0; m_op1 = 0; m_waddr = 0; m_aluop = 0; m_alusel = 0;
    endtask

    // One cycle: compare at negedge, then advance the model across the posedge.
    task automatic tick();
        logic hz, sreq;
        logic [DW-1:0] o0, o1;
        @(negedge clk);
        hz = f_hz(); sreq = hz && !flush; o0 = f_op(0); o1 = f_op(1);
        chk("stall_req", stall_req, sreq);
        chk("branch_flag", branch_flag, f_bflag());
        chk("branch_addr", branch_addr, btarget);
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_op0", ex_op0, m_op0);
        chk("ex_op1", ex_op1, m_op1);
        chk("ex_we", ex_we, m_we);
        chk("ex_waddr", ex_waddr, m_waddr);
        chk("ex_aluop", ex_aluop, m_aluop);
        chk("ex_alusel", ex_alusel, m_alusel);
`ifdef ID_STAT_EN
        chk("stall_cnt", stall_cnt, m_scnt);
        chk("bubble_cnt", bubble_cnt, m_bcnt);
`endif
        @(posedge clk);
        if (!rst) begin
            m_bubble(); m_scnt = 0; m_bcnt = 0;
        end else begin
            if (sreq && m_scnt < 65535) m_scnt++;
            if ((flush || (!stall && (hz || !in_valid))) && m_bcnt < 65535) m_bcnt++;
            if (flush) m_bubble();
            else if (stall) ;
            else if (hz || !in_valid) m_bubble();
            else begin
                m_valid = 1; m_op0 = o0; m_op1 = o1; m_we = we;
                m_waddr = waddr; m_aluop = aluop; m_alusel = alusel;
            end
        end
        #1;
    endtask

    task automatic idle();
        in_valid = 0; re = 0; raddr = 0; rf_data = 0; imm = 0; we = 0; waddr = 0;
        aluop = 0; alusel = 0; branch = 0; bcond = 0; btarget = 0; fwd_we = 0;
        fwd_waddr = 0; fwd_wdata = 0; ex_load = 0; stall = 0; flush = 0;
    endtask

    initial begin
        m_bubble(); m_scnt = 0; m_bcnt = 0;
        idle(); rst = 0;
        tick(); tick();
        chk("reset_valid", ex_valid, 0);
        rst = 1;

        // Forwarding priority, port 1 on immediate 0x00FF.
        in_valid = 1; re = 2'b01; raddr = {4'd0, 4'd3}; imm = 16'h00FF;
        fwd_we = 2'b11; fwd_waddr = {4'd3, 4'd3}; fwd_wdata = {16'h2222, 16'h1111};
        rf_data = {16'h0000, 16'h3333}; we = 1; waddr = 4'd6; aluop = 8'h21; alusel = 3'd1;
        tick();
        chk("lit_fwd0", ex_op0, 16'h1111);
        chk("lit_imm", ex_op1, 16'h00FF);
        fwd_we = 2'b10; tick();
        chk("lit_fwd1", ex_op0, 16'h2222);
        fwd_we = 2'b00; tick();
        chk("lit_rf", ex_op0, 16'h3333);

        // R0 forwarded like any other register.
        raddr = {4'd0, 4'd0}; re = 2'b11; fwd_we = 2'b01; fwd_waddr = {4'd9, 4'd0};
        fwd_wdata = {16'h0, 16'h0BAD}; tick();
        chk("lit_r0", ex_op1, 16'h0BAD);

        // Load-use on port 1.
        re = 2'b10; raddr = {4'd5, 4'd1}; fwd_we = 2'b01; fwd_waddr = {4'd0, 4'd5};
        fwd_wdata = {16'h0, 16'hABCD}; ex_load = 1; #1;
        chk("lit_stall_req", stall_req, 1);
        tick();
        chk("lit_lu_bubble", ex_valid, 0);
        ex_load = 0; tick();
        chk("lit_lu_op1", ex_op1, 16'hABCD);
        chk("lit_lu_valid", ex_valid, 1);

        // Branches: BEQZ taken, not taken, suppressed by hazard.
        branch = 1; bcond = 2'b01; btarget = 16'h0040; re = 2'b01; raddr = {4'd0, 4'd2};
        fwd_we = 2'b01; fwd_waddr = {4'd0, 4'd2}; fwd_wdata = 0; #1;
        chk("lit_beqz_t", branch_flag, 1);
        chk("lit_baddr", branch_addr, 16'h0040);
        tick();
        fwd_wdata = {16'h0, 16'h0001}; #1;
        chk("lit_beqz_nt", branch_flag, 0);
        tick();
        fwd_wdata = 0; ex_load = 1; #1;
        chk("lit_beqz_hz", branch_flag, 0);
        tick();
        ex_load = 0;
        for (int c = 0; c < 4; c++) begin
            bcond = c[1:0]; fwd_wdata = {16'h0, 16'(c & 1)}; tick();
        end
        branch = 0;

        // Stall holds for 3 cycles, then flush with stall bubbles.
        re = 2'b11; raddr = {4'd1, 4'd2}; fwd_we = 0; rf_data = {16'h5555, 16'h7777};
        we = 1; waddr = 4'd7; aluop = 8'h5A; alusel = 3'd3; tick();
        chk("lit_pre_stall", ex_op0, 16'h7777);
        stall = 1; rf_data = {16'h1, 16'h2}; aluop = 8'h00; we = 0;
        tick(); tick(); tick();
        chk("lit_hold_op0", ex_op0, 16'h7777);
        chk("lit_hold_aluop", ex_aluop, 8'h5A);
        // Stall together with hazard: hold wins, request still raised.
        fwd_we = 2'b01; fwd_waddr = {4'd0, 4'd2}; ex_load = 1; tick();
        chk("lit_hold_hz", ex_valid, 1);
        flush = 1; tick();
        chk("lit_flush", ex_valid, 0);
        flush = 0; stall = 0; ex_load = 0; fwd_we = 0;

        // Reset mid-pipeline, with a hazard present during reset.
        we = 1; aluop = 8'h33; tick();
        chk("lit_pre_rst", ex_valid, 1);
        rst = 0; fwd_we = 2'b01; ex_load = 1; tick();
        chk("lit_rst_valid", ex_valid, 0);
        chk("lit_rst_aluop", ex_aluop, 0);
        rst = 1; fwd_we = 0; ex_load = 0; tick();

`ifdef ID_STAT_EN
        // Fresh counters: 2 hazard cycles then 1 flush.
        rst = 0; tick(); rst = 1;
        in_valid = 1; re = 2'b01; raddr = {4'd0, 4'd4}; fwd_we = 2'b01;
        fwd_waddr = {4'd0, 4'd4}; ex_load = 1; tick(); tick();
        ex_load = 0; flush = 1; tick(); flush = 0;
        chk("lit_stall_cnt", stall_cnt, 2);
        chk("lit_bubble_cnt", bubble_cnt, 3);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
